// File: rtl/instr_encoder_if.sv
// Field-bundle input stream and encoded-word output stream of instr_encoder.
// The slave modport is the encoder's view; master is the producer/consumer side.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm;
   logic        load_base;
   logic [31:0] base_addr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr;
   logic [31:0] addr;
   logic        err;
   logic [15:0] err_cnt;

   modport master (
      output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm,
             load_base, base_addr, out_ready,
      input  in_ready, out_valid, instr, addr, err, err_cnt
   );

   modport slave (
      input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm,
             load_base, base_addr, out_ready,
      output in_ready, out_valid, instr, addr, err, err_cnt
   );
endinterface

// File: rtl/instr_encoder.sv
// RV32I field-bundle to instruction-word encoder with a single skid-free output
// register, address assignment and illegal-bundle substitution.
module instr_encoder (
   input  logic           clk,
   input  logic           rst,
   instr_encoder_if.slave bus
);
   typedef enum logic [2:0] {
      FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
   } fmt_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   fmt_t        fmt;
   logic [31:0] imm;
   logic [6:0]  opcode;
   logic [6:0]  funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] enc;
   logic        illegal;
   logic        ext11;
   logic        ext12;
   logic        ext20;
   logic        sh_f7_ok;
   logic        accept;
   logic [31:0] cnt;
   logic [31:0] base;
   logic [31:0] slot_addr;

   assign imm    = bus.imm;
   assign opcode = bus.opcode;
   assign funct7 = bus.funct7;
   assign funct3 = bus.funct3;
   assign rd     = bus.rd;
   assign rs1    = bus.rs1;
   assign rs2    = bus.rs2;

   assign bus.in_ready = ~bus.out_valid | bus.out_ready;
   assign accept       = bus.in_valid & bus.in_ready;
   assign base         = bus.base_addr & 32'hFFFF_FFFC;
   assign slot_addr    = bus.load_base ? base : cnt;

   // Upper immediate bits must all replicate the sign of the encodable field.
   assign ext11    = (&imm[31:11]) | ~(|imm[31:11]);
   assign ext12    = (&imm[31:12]) | ~(|imm[31:12]);
   assign ext20    = (&imm[31:20]) | ~(|imm[31:20]);
   assign sh_f7_ok = (funct7 == 7'b0000000) ||
                     (funct7 == 7'b0100000 && funct3 == 3'b101);

   always_comb begin
      case (opcode)
         7'b0110111, 7'b0010111: fmt = FMT_U;
         7'b1101111:             fmt = FMT_J;
         7'b0010011:             fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SH : FMT_I;
         7'b1100111, 7'b0000011: fmt = FMT_I;
         7'b1100011:             fmt = FMT_B;
         7'b0100011:             fmt = FMT_S;
         7'b0110011:             fmt = FMT_R;
         default:                fmt = FMT_BAD;
      endcase
   end

   always_comb begin
      enc     = '0;
      illegal = 1'b0;
      case (fmt)
         FMT_U: begin
            enc     = {imm[31:12], rd, opcode};
            illegal = |imm[11:0];
         end
         FMT_J: begin
            enc     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            illegal = ~ext20 | imm[0];
         end
         FMT_I: begin
            enc     = {imm[11:0], rs1, funct3, rd, opcode};
            illegal = ~ext11;
         end
         FMT_SH: begin
            enc     = {funct7, imm[4:0], rs1, funct3, rd, opcode};
            illegal = (|imm[31:5]) | ~sh_f7_ok;
         end
         FMT_S: begin
            enc     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            illegal = ~ext11;
         end
         FMT_B: begin
            enc     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            illegal = ~ext12 | imm[0];
         end
         FMT_R: begin
            enc     = {funct7, rs2, rs1, funct3, rd, opcode};
            illegal = 1'b0;
         end
         default: begin
            enc     = '0;
            illegal = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.instr     <= '0;
         bus.addr      <= '0;
         bus.err       <= 1'b0;
         bus.err_cnt   <= '0;
         cnt           <= '0;
      end else if (accept) begin
         bus.out_valid <= 1'b1;
         bus.instr     <= illegal ? NOP : enc;
         bus.addr      <= slot_addr;
         bus.err       <= illegal;
         cnt           <= slot_addr + 32'd4;
         if (illegal && bus.err_cnt != '1)
            bus.err_cnt <= bus.err_cnt + 16'd1;
      end else begin
         if (bus.out_ready)
            bus.out_valid <= 1'b0;
         if (bus.load_base)
            cnt <= base;
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed plus randomized bench for instr_encoder against a range-based
// legality model and an independent instruction-word decoder.
module tb_instr_encoder;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_encoder_if bus ();
   instr_encoder dut (.clk(clk), .rst(rst), .bus(bus));

   typedef enum {K_R, K_I, K_SH, K_S, K_B, K_U, K_J, K_X} kind_t;

   typedef struct {
      logic [6:0]  opc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      bit          bad;
      logic [31:0] addr;
   } item_t;

   typedef struct packed {
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   bit          m_valid;
   item_t       m_item;
   logic [31:0] m_cnt;
   int          m_errs;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic kind_t kind_of(input logic [6:0] opc, input logic [2:0] f3);
      case (opc)
         7'h37, 7'h17: return K_U;
         7'h6F:        return K_J;
         7'h13:        return (f3 == 3'd1 || f3 == 3'd5) ? K_SH : K_I;
         7'h67, 7'h03: return K_I;
         7'h63:        return K_B;
         7'h23:        return K_S;
         7'h33:        return K_R;
         default:      return K_X;
      endcase
   endfunction

   // Legality expressed as signed value ranges rather than bit patterns.
   function automatic bit is_bad(input kind_t k, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm);
      longint s;
      s = longint'($signed(imm));
      case (k)
         K_I, K_S: return !(s >= -2048 && s <= 2047);
         K_B:      return !(s >= -4096 && s <= 4095 && imm % 2 == 0);
         K_J:      return !(s >= -1048576 && s <= 1048575 && imm % 2 == 0);
         K_U:      return imm % 4096 != 0;
         K_SH:     return !(imm < 32 && (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5)));
         K_R:      return 1'b0;
         default:  return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] dec_imm(input kind_t k, input logic [31:0] w);
      case (k)
         K_I:     return {{20{w[31]}}, w[31:20]};
         K_SH:    return {27'b0, w[24:20]};
         K_S:     return {{20{w[31]}}, w[31:25], w[11:7]};
         K_B:     return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         K_J:     return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         K_U:     return {w[31:12], 12'b0};
         default: return 32'b0;
      endcase
   endfunction

   function automatic logic [63:0] tuple(input kind_t k, input logic [6:0] opc,
         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
      case (k)
         K_U, K_J:  return {opc, rd, 3'b0, 5'b0, 5'b0, 7'b0, imm};
         K_I:       return {opc, rd, f3, rs1, 5'b0, 7'b0, imm};
         K_SH:      return {opc, rd, f3, rs1, 5'b0, f7, imm};
         K_S, K_B:  return {opc, 5'b0, f3, rs1, rs2, 7'b0, imm};
         default:   return {opc, rd, f3, rs1, rs2, f7, 32'b0};
      endcase
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_cnt   = 32'd0;
      m_errs  = 0;
   endtask

   task automatic put(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm);
      bus.opcode = opc; bus.funct3 = f3; bus.funct7 = f7;
      bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
   endtask

   task automatic rand_bundle(input bit legal);
      logic [6:0] ops [9];
      logic [6:0] opc;
      logic [2:0] f3;
      logic [6:0] f7;
      logic [31:0] imm;
      kind_t k;
      ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h63, 7'h23, 7'h33};
      opc = ops[$urandom_range(0, 8)];
      if (!legal && $urandom_range(0, 9) == 0) opc = 7'($urandom());
      f3 = 3'($urandom());
      f7 = 7'($urandom());
      imm = $urandom();
      k = kind_of(opc, f3);
      if (legal || $urandom_range(0, 1) == 1) begin
         case (k)
            K_I, K_S: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            K_B:      imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
            K_J:      imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
            K_U:      imm = $urandom() & 32'hFFFF_F000;
            K_SH: begin
               imm = 32'($urandom_range(0, 31));
               f7  = (f3 == 3'd5 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            end
            default: ;
         endcase
      end
      put(opc, f3, f7, 5'($urandom()), 5'($urandom()), 5'($urandom()), imm);
   endtask

   task automatic check_out();
      kind_t k;
      check("out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("err_cnt", 64'(bus.err_cnt), 64'(m_errs));
      if (m_valid) begin
         check("addr", 64'(bus.addr), 64'(m_item.addr));
         check("err", 64'(bus.err), 64'(m_item.bad));
         if (m_item.bad) begin
            check("nop", 64'(bus.instr), 64'h13);
         end else begin
            k = kind_of(m_item.opc, m_item.f3);
            check("fields",
                  tuple(k, bus.instr[6:0], bus.instr[11:7], bus.instr[19:15], bus.instr[24:20],
                        bus.instr[14:12], bus.instr[31:25], dec_imm(k, bus.instr)),
                  tuple(k, m_item.opc, m_item.rd, m_item.rs1, m_item.rs2,
                        m_item.f3, m_item.f7, m_item.imm));
         end
      end
   endtask

   // Entered at posedge+1 with inputs already driven; returns at the next posedge+1.
   task automatic cycle();
      bit          ready;
      item_t       it;
      logic [31:0] a;
      #1;
      ready = !m_valid || bus.out_ready === 1'b1;
      check("in_ready", 64'(bus.in_ready), 64'(ready));
      if (bus.in_valid && ready) begin
         it.opc = bus.opcode; it.rd = bus.rd; it.rs1 = bus.rs1; it.rs2 = bus.rs2;
         it.f3 = bus.funct3; it.f7 = bus.funct7; it.imm = bus.imm;
         it.bad = is_bad(kind_of(bus.opcode, bus.funct3), bus.funct3, bus.funct7, bus.imm);
         a = bus.load_base ? (bus.base_addr & 32'hFFFF_FFFC) : m_cnt;
         it.addr = a;
         m_cnt = a + 32'd4;
         if (it.bad && m_errs < 65535) m_errs++;
         m_item = it;
         m_valid = 1'b1;
      end else begin
         if (bus.out_ready) m_valid = 1'b0;
         if (bus.load_base) m_cnt = bus.base_addr & 32'hFFFF_FFFC;
      end
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, "_instr"}, 64'(bus.instr), 64'd0);
      check({tag, "_addr"}, 64'(bus.addr), 64'd0);
      check({tag, "_err"}, 64'(bus.err), 64'd0);
      check({tag, "_err_cnt"}, 64'(bus.err_cnt), 64'd0);
   endtask

   vec_t vecs [13];

   initial begin
      vecs = '{
         '{7'h13, 3'd0, 7'h00, 32'h0000_07FF}, '{7'h13, 3'd0, 7'h00, 32'h0000_0800},
         '{7'h03, 3'd2, 7'h00, 32'hFFFF_F800}, '{7'h23, 3'd2, 7'h00, 32'hFFFF_F7FF},
         '{7'h63, 3'd0, 7'h00, 32'h0000_0FFE}, '{7'h63, 3'd0, 7'h00, 32'h0000_1000},
         '{7'h63, 3'd1, 7'h00, 32'h0000_0003}, '{7'h6F, 3'd0, 7'h00, 32'hFFF0_0000},
         '{7'h13, 3'd1, 7'h20, 32'h0000_0005}, '{7'h13, 3'd5, 7'h20, 32'h0000_001F},
         '{7'h13, 3'd5, 7'h00, 32'h0000_0020}, '{7'h37, 3'd0, 7'h00, 32'hABCD_E000},
         '{7'h17, 3'd0, 7'h00, 32'h0000_0001}};
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.load_base = 1'b0; bus.base_addr = '0;
      put(7'h0, 3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 32'd0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst = 1'b0;

      // ADDI x1, x0, -1 as first bundle after reset
      bus.out_ready = 1'b1; bus.in_valid = 1'b1;
      put(7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
      cycle();
      check("addi_word", 64'(bus.instr), 64'hFFF0_0093);
      check("first_addr", 64'(bus.addr), 64'd0);

      put(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
      cycle();
      check("jal_word", 64'(bus.instr), 64'h0010_00EF);
      put(7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0801);
      cycle();
      check("jal_odd_word", 64'(bus.instr), 64'h13);
      check("jal_odd_cnt", 64'(bus.err_cnt), 64'd1);

      // Base load coinciding with an accept, then wrap on the next accept
      bus.load_base = 1'b1; bus.base_addr = 32'hFFFF_FFFC;
      rand_bundle(1'b1);
      cycle();
      check("base_addr", 64'(bus.addr), 64'hFFFF_FFFC);
      bus.load_base = 1'b0;
      rand_bundle(1'b1);
      cycle();
      check("wrap_addr", 64'(bus.addr), 64'd0);

      // Backpressure: drain, then stall three cycles with a bundle waiting
      bus.in_valid = 1'b0;
      cycle();
      bus.in_valid = 1'b1; bus.out_ready = 1'b0;
      repeat (4) begin
         rand_bundle(1'b1);
         cycle();
      end
      bus.out_ready = 1'b1;
      repeat (3) begin
         rand_bundle(1'b1);
         cycle();
      end

      // Base load with no accept; low address bits dropped
      bus.in_valid = 1'b0; bus.load_base = 1'b1; bus.base_addr = 32'h1234_5677;
      cycle();
      bus.load_base = 1'b0; bus.in_valid = 1'b1;
      rand_bundle(1'b1);
      cycle();
      check("loaded_addr", 64'(bus.addr), 64'h1234_5674);

      foreach (vecs[i]) begin
         put(vecs[i].opc, vecs[i].f3, vecs[i].f7, 5'd3, 5'd7, 5'd9, vecs[i].imm);
         cycle();
      end

      for (int i = 0; i < 60; i++) begin
         rand_bundle(1'b1);
         cycle();
      end

      for (int i = 0; i < 400; i++) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.load_base = ($urandom_range(0, 15) == 0);
         bus.base_addr = $urandom();
         rand_bundle(1'b0);
         cycle();
      end

      // Build err_cnt=5 with a word held, then assert reset between edges
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.load_base = 1'b0;
      put(7'h00, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 32'd0);
      repeat (5) cycle();
      check("pre_rst_cnt", 64'(bus.err_cnt), 64'd5);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_reset_state("async_rst");
      model_reset();
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.in_valid = 1'b1;
      put(7'h33, 3'd0, 7'h20, 5'd4, 5'd5, 5'd6, 32'd0);
      cycle();
      check("post_rst_addr", 64'(bus.addr), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
